// File: rtl/vx_smem_serializer.sv
// Banked shared memory that takes one warp request and serializes bank conflicts internally.
// States: IDLE accept request | ISSUE drain pending lanes | WAIT read pipeline drains | RSP hold merged response
module vx_smem_serializer #(
    parameter int SIZE_BYTES   = 16384,
    parameter int NUM_BANKS    = 4,
    parameter int WORD_SIZE    = 4,
    parameter int NUM_REQS     = 4,
    parameter int ADDR_WIDTH   = 30,
    parameter int TAG_WIDTH    = 10,
    parameter int READ_LATENCY = 1,
    parameter int BCAST_ENABLE = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            req_valid,
    input  logic                            req_rw,
    input  logic [NUM_REQS-1:0]             req_tmask,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQS*WORD_SIZE-1:0]   req_byteen,
    input  logic [NUM_REQS*WORD_SIZE*8-1:0] req_data,
    input  logic [TAG_WIDTH-1:0]            req_tag,
    output logic                            req_ready,
    output logic                            rsp_valid,
    output logic [NUM_REQS-1:0]             rsp_tmask,
    output logic [NUM_REQS*WORD_SIZE*8-1:0] rsp_data,
    output logic [TAG_WIDTH-1:0]            rsp_tag,
    input  logic                            rsp_ready,
    output logic [31:0]                     perf_conflict_cycles
);

    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int DEPTH     = SIZE_BYTES / (WORD_SIZE * NUM_BANKS);
    localparam int LINE_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int LANE_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int DW        = WORD_SIZE * 8;

    if (!(READ_LATENCY == 1 || READ_LATENCY == 2)) begin : g_bad_latency
        $error("vx_smem_serializer: READ_LATENCY must be 1 or 2");
    end
    if (NUM_BANKS > NUM_REQS) begin : g_bad_banks
        $error("vx_smem_serializer: NUM_BANKS must not exceed NUM_REQS");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RSP} state_t;
    state_t state;

    logic                  rw_q;
    logic [NUM_REQS-1:0]   tmask_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [ADDR_WIDTH-1:0] addr_q   [NUM_REQS];
    logic [WORD_SIZE-1:0]  byteen_q [NUM_REQS];
    logic [DW-1:0]         data_q   [NUM_REQS];

    logic [NUM_REQS-1:0]   pending;
    logic [NUM_REQS-1:0]   pending_nxt;
    logic [NUM_REQS-1:0]   served;
    logic                  first_issue;
    logic [1:0]            wait_cnt;

    logic [BANK_W-1:0]     lane_bank   [NUM_REQS];
    logic [LINE_BITS-1:0]  lane_line   [NUM_REQS];
    logic [NUM_BANKS-1:0]  bank_en;
    logic [LANE_W-1:0]     bank_lane   [NUM_BANKS];
    logic [LINE_BITS-1:0]  bank_line   [NUM_BANKS];
    logic [NUM_REQS-1:0]   bank_served [NUM_BANKS];

    logic [DW-1:0]         mem [NUM_BANKS][DEPTH];
    logic [DW-1:0]         rd_pipe1  [NUM_BANKS];
    logic [DW-1:0]         rd_pipe2  [NUM_BANKS];
    logic [NUM_REQS-1:0]   cap_pipe1 [NUM_BANKS];
    logic [NUM_REQS-1:0]   cap_pipe2 [NUM_BANKS];
    logic [DW-1:0]         cap_data  [NUM_BANKS];
    logic [NUM_REQS-1:0]   cap_mask  [NUM_BANKS];
    logic [DW-1:0]         rsp_data_q [NUM_REQS];

    assign req_ready = (state == IDLE);
    assign rsp_tag   = tag_q;

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            lane_bank[i] = BANK_W'(addr_q[i] & ADDR_WIDTH'(NUM_BANKS - 1));
            lane_line[i] = LINE_BITS'(addr_q[i] >> BANK_BITS);
        end
    end

    // Per bank: lowest pending lane wins; same-line reads ride along when broadcast is on.
    always_comb begin
        bank_en = '0;
        served  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_lane[b]   = '0;
            bank_line[b]   = '0;
            bank_served[b] = '0;
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (!bank_en[b] && pending[i] && lane_bank[i] == BANK_W'(b)) begin
                    bank_en[b]   = 1'b1;
                    bank_lane[b] = LANE_W'(i);
                    bank_line[b] = lane_line[i];
                end
            end
            for (int i = 0; i < NUM_REQS; i++) begin
                if (pending[i] && lane_bank[i] == BANK_W'(b)
                    && (bank_lane[b] == LANE_W'(i)
                        || (!rw_q && BCAST_ENABLE != 0 && lane_line[i] == bank_line[b])))
                    bank_served[b][i] = 1'b1;
            end
            served = served | bank_served[b];
        end
        pending_nxt = pending & ~served;
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (state == ISSUE && bank_en[b]) begin
                if (rw_q) begin
                    for (int k = 0; k < WORD_SIZE; k++) begin
                        if (byteen_q[bank_lane[b]][k])
                            mem[b][bank_line[b]][8*k +: 8] <= data_q[bank_lane[b]][8*k +: 8];
                    end
                end else begin
                    rd_pipe1[b] <= mem[b][bank_line[b]];
                end
            end
            rd_pipe2[b] <= rd_pipe1[b];
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            cap_data[b] = (READ_LATENCY == 2) ? rd_pipe2[b]  : rd_pipe1[b];
            cap_mask[b] = (READ_LATENCY == 2) ? cap_pipe2[b] : cap_pipe1[b];
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (cap_mask[b][i])
                    rsp_data_q[i] <= cap_data[b];
            end
        end
    end

    always_comb begin
        rsp_data = '0;
        for (int i = 0; i < NUM_REQS; i++)
            rsp_data[i*DW +: DW] = rsp_data_q[i];
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            rw_q    <= req_rw;
            tmask_q <= req_tmask;
            tag_q   <= req_tag;
            for (int i = 0; i < NUM_REQS; i++) begin
                addr_q[i]   <= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                byteen_q[i] <= req_byteen[i*WORD_SIZE +: WORD_SIZE];
                data_q[i]   <= req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            rsp_valid            <= 1'b0;
            rsp_tmask            <= '0;
            perf_conflict_cycles <= '0;
            pending              <= '0;
            first_issue          <= 1'b0;
            wait_cnt             <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                cap_pipe1[b] <= '0;
                cap_pipe2[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                cap_pipe1[b] <= (state == ISSUE && !rw_q) ? bank_served[b] : '0;
                cap_pipe2[b] <= cap_pipe1[b];
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        pending     <= req_tmask;
                        first_issue <= 1'b1;
                        if (req_tmask != '0)
                            state <= ISSUE;
                    end
                end
                ISSUE: begin
                    pending     <= pending_nxt;
                    first_issue <= 1'b0;
                    if (!first_issue)
                        perf_conflict_cycles <= perf_conflict_cycles + 32'd1;
                    if (pending_nxt == '0) begin
                        if (rw_q) begin
                            state <= IDLE;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= 2'(READ_LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    // Last lane lands in its response register on the same edge we enter RSP.
                    if (wait_cnt == 2'd0) begin
                        state     <= RSP;
                        rsp_valid <= 1'b1;
                        rsp_tmask <= tmask_q;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vx_smem_serializer.sv
// Directed bench: dut_a uses latency 1 with broadcast, dut_b latency 2 without broadcast.
module tb_vx_smem_serializer;

    localparam int NR = 4;
    localparam int AW = 30;
    localparam int TW = 10;

    logic           clk = 1'b0;
    logic           reset;
    logic           req_valid_a, req_valid_b;
    logic           req_rw;
    logic [NR-1:0]  req_tmask;
    logic [NR*AW-1:0] req_addr;
    logic [NR*4-1:0]  req_byteen;
    logic [NR*32-1:0] req_data;
    logic [TW-1:0]  req_tag;
    logic           rsp_ready_a, rsp_ready_b;

    logic           req_ready_a, req_ready_b;
    logic           rsp_valid_a, rsp_valid_b;
    logic [NR-1:0]  rsp_tmask_a, rsp_tmask_b;
    logic [NR*32-1:0] rsp_data_a, rsp_data_b;
    logic [TW-1:0]  rsp_tag_a, rsp_tag_b;
    logic [31:0]    perf_a, perf_b;

    logic [AW-1:0]  v_addr [NR];
    logic [31:0]    v_data [NR];
    logic [3:0]     v_be   [NR];
    logic [31:0]    e_data [NR];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vx_smem_serializer #(.READ_LATENCY(1), .BCAST_ENABLE(1)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_a), .req_rw(req_rw), .req_tmask(req_tmask),
        .req_addr(req_addr), .req_byteen(req_byteen), .req_data(req_data),
        .req_tag(req_tag), .req_ready(req_ready_a),
        .rsp_valid(rsp_valid_a), .rsp_tmask(rsp_tmask_a), .rsp_data(rsp_data_a),
        .rsp_tag(rsp_tag_a), .rsp_ready(rsp_ready_a),
        .perf_conflict_cycles(perf_a)
    );

    vx_smem_serializer #(.READ_LATENCY(2), .BCAST_ENABLE(0)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_b), .req_rw(req_rw), .req_tmask(req_tmask),
        .req_addr(req_addr), .req_byteen(req_byteen), .req_data(req_data),
        .req_tag(req_tag), .req_ready(req_ready_b),
        .rsp_valid(rsp_valid_b), .rsp_tmask(rsp_tmask_b), .rsp_data(rsp_data_b),
        .rsp_tag(rsp_tag_b), .rsp_ready(rsp_ready_b),
        .perf_conflict_cycles(perf_b)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic get_ready(input bit sel);
        return sel ? req_ready_b : req_ready_a;
    endfunction
    function automatic logic get_valid(input bit sel);
        return sel ? rsp_valid_b : rsp_valid_a;
    endfunction
    function automatic logic [31:0] get_perf(input bit sel);
        return sel ? perf_b : perf_a;
    endfunction
    function automatic logic [NR-1:0] get_tmask(input bit sel);
        return sel ? rsp_tmask_b : rsp_tmask_a;
    endfunction
    function automatic logic [TW-1:0] get_tag(input bit sel);
        return sel ? rsp_tag_b : rsp_tag_a;
    endfunction
    function automatic logic [31:0] get_lane(input bit sel, input int i);
        return sel ? rsp_data_b[32*i +: 32] : rsp_data_a[32*i +: 32];
    endfunction

    task automatic set_addr(input logic [AW-1:0] a0, a1, a2, a3);
        v_addr[0] = a0; v_addr[1] = a1; v_addr[2] = a2; v_addr[3] = a3;
        for (int i = 0; i < NR; i++) v_be[i] = 4'hF;
    endtask

    task automatic set_exp(input logic [31:0] d0, d1, d2, d3);
        e_data[0] = d0; e_data[1] = d1; e_data[2] = d2; e_data[3] = d3;
    endtask

    // Drives at a falling edge, accepts on the next rising edge (edge 0), returns just after edge 0.
    task automatic send(input bit sel, input bit rw, input logic [NR-1:0] tmask, input logic [TW-1:0] tag);
        @(negedge clk);
        req_rw    = rw;
        req_tmask = tmask;
        req_tag   = tag;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]   = v_addr[i];
            req_byteen[i*4 +: 4]   = v_be[i];
            req_data[i*32 +: 32]   = v_data[i];
        end
        check("ready_before_req", get_ready(sel), 1'b1);
        if (sel) req_valid_b = 1'b1;
        else     req_valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
    endtask

    task automatic wait_ready(input bit sel, input int exp_edges, input string tag);
        int n = 0;
        while (!get_ready(sel) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n), 64'(exp_edges));
    endtask

    task automatic wait_rsp(input bit sel, input int exp_edges, input string tag);
        int n = 0;
        while (!get_valid(sel) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n), 64'(exp_edges));
    endtask

    task automatic check_rsp(input bit sel, input logic [NR-1:0] tmask, input logic [TW-1:0] tag);
        check("rsp_valid", get_valid(sel), 1'b1);
        check("rsp_tmask", get_tmask(sel), tmask);
        check("rsp_tag", get_tag(sel), tag);
        for (int i = 0; i < NR; i++)
            if (tmask[i]) check($sformatf("rsp_data_lane%0d", i), get_lane(sel, i), e_data[i]);
    endtask

    task automatic fire(input bit sel);
        @(negedge clk);
        check("valid_after_fire", get_valid(sel), 1'b0);
        check("ready_after_fire", get_ready(sel), 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        req_rw = 1'b0; req_tmask = '0; req_addr = '0; req_byteen = '0; req_data = '0; req_tag = '0;
        rsp_ready_a = 1'b1; rsp_ready_b = 1'b1;
        for (int i = 0; i < NR; i++) begin v_addr[i] = '0; v_data[i] = '0; v_be[i] = 4'hF; end
        repeat (3) @(negedge clk);
        check("reset_ready", req_ready_a, 1'b1);
        check("reset_rsp_valid", rsp_valid_a, 1'b0);
        check("reset_rsp_tmask", rsp_tmask_a, 4'h0);
        check("reset_perf_a", perf_a, 32'd0);
        check("reset_perf_b", perf_b, 32'd0);
        reset = 1'b0;

        // Conflict-free write then read
        set_addr(0, 1, 2, 3);
        v_data[0] = 32'hA0A0_0000; v_data[1] = 32'hA0A0_0001;
        v_data[2] = 32'hA0A0_0002; v_data[3] = 32'hA0A0_0003;
        send(0, 1'b1, 4'hF, 10'd5);
        wait_ready(0, 1, "wr_cf_edges");
        check("wr_cf_perf", perf_a, 32'd0);
        send(0, 1'b0, 4'hF, 10'd7);
        wait_rsp(0, 2, "rd_cf_edges");
        set_exp(32'hA0A0_0000, 32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003);
        check_rsp(0, 4'hF, 10'd7);
        check("rd_cf_perf", perf_a, 32'd0);
        fire(0);

        // Three-way bank-0 write conflict plus one bank-1 lane: C=3
        set_addr(4, 8, 12, 13);
        v_data[0] = 32'h4444_4444; v_data[1] = 32'h8888_8888;
        v_data[2] = 32'hCCCC_CCCC; v_data[3] = 32'h1313_1313;
        send(0, 1'b1, 4'hF, 10'd1);
        wait_ready(0, 3, "wr_conf_edges");
        check("wr_conf_perf", perf_a, 32'd2);

        // Full read conflict on bank 0: C=4
        set_addr(0, 4, 8, 12);
        send(0, 1'b0, 4'hF, 10'd2);
        wait_rsp(0, 5, "rd_conf_edges");
        set_exp(32'hA0A0_0000, 32'h4444_4444, 32'h8888_8888, 32'hCCCC_CCCC);
        check_rsp(0, 4'hF, 10'd2);
        check("rd_conf_perf", perf_a, 32'd5);
        fire(0);

        // Broadcast read: C=1
        set_addr(8, 8, 8, 8);
        send(0, 1'b0, 4'hF, 10'd3);
        wait_rsp(0, 2, "bcast_edges");
        set_exp(32'h8888_8888, 32'h8888_8888, 32'h8888_8888, 32'h8888_8888);
        check_rsp(0, 4'hF, 10'd3);
        check("bcast_perf", perf_a, 32'd5);
        fire(0);

        // Same-address write race: lane 2 partial bytes land after lane 0
        set_addr(4, 0, 4, 0);
        v_be[2] = 4'h3;
        v_data[0] = 32'h1111_1111; v_data[1] = 32'h0;
        v_data[2] = 32'h0000_BBBB; v_data[3] = 32'h0;
        send(0, 1'b1, 4'b0101, 10'd4);
        wait_ready(0, 2, "race_edges");
        check("race_perf", perf_a, 32'd6);
        set_addr(4, 0, 0, 0);
        send(0, 1'b0, 4'b0001, 10'd9);
        wait_rsp(0, 2, "race_rd_edges");
        set_exp(32'h1111_BBBB, 32'h0, 32'h0, 32'h0);
        check_rsp(0, 4'b0001, 10'd9);
        fire(0);

        // dut_b: latency 2, no broadcast
        set_addr(8, 9, 10, 11);
        v_data[0] = 32'hE000_0008; v_data[1] = 32'hE000_0009;
        v_data[2] = 32'hE000_000A; v_data[3] = 32'hE000_000B;
        send(1, 1'b1, 4'hF, 10'd5);
        wait_ready(1, 1, "b_wr_edges");
        send(1, 1'b0, 4'hF, 10'd8);
        wait_rsp(1, 3, "b_rd_edges");
        set_exp(32'hE000_0008, 32'hE000_0009, 32'hE000_000A, 32'hE000_000B);
        check_rsp(1, 4'hF, 10'd8);
        check("b_rd_perf", perf_b, 32'd0);
        fire(1);

        rsp_ready_b = 1'b0;
        set_addr(8, 8, 8, 8);
        send(1, 1'b0, 4'hF, 10'd6);
        wait_rsp(1, 6, "b_nobcast_edges");
        check("b_nobcast_perf", perf_b, 32'd3);
        set_exp(32'hE000_0008, 32'hE000_0008, 32'hE000_0008, 32'hE000_0008);
        for (int c = 0; c < 5; c++) begin
            check_rsp(1, 4'hF, 10'd6);
            check("b_hold_ready", req_ready_b, 1'b0);
            @(negedge clk);
        end
        check_rsp(1, 4'hF, 10'd6);
        rsp_ready_b = 1'b1;
        fire(1);

        // Reset while dut_a sits in WAIT
        set_addr(0, 4, 8, 12);
        send(0, 1'b0, 4'hF, 10'd11);
        repeat (4) @(negedge clk);
        check("pre_reset_valid", rsp_valid_a, 1'b0);
        check("pre_reset_ready", req_ready_a, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_wait_valid", rsp_valid_a, 1'b0);
        check("rst_wait_ready", req_ready_a, 1'b1);
        check("rst_wait_perf", perf_a, 32'd0);
        check("rst_wait_tmask", rsp_tmask_a, 4'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_no_rsp", rsp_valid_a, 1'b0);
        end
        set_addr(4, 0, 0, 0);
        send(0, 1'b0, 4'b0001, 10'd13);
        wait_rsp(0, 2, "post_rst_edges");
        set_exp(32'h1111_BBBB, 32'h0, 32'h0, 32'h0);
        check_rsp(0, 4'b0001, 10'd13);
        fire(0);

        // Empty mask: accepted and dropped
        send(0, 1'b0, 4'h0, 10'd12);
        wait_ready(0, 0, "empty_ready");
        for (int c = 0; c < 4; c++) begin
            check("empty_no_rsp", rsp_valid_a, 1'b0);
            check("empty_ready_hold", req_ready_a, 1'b1);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
